// File: rtl/rev_xbar_vc_bind_if.sv
// Bundle of reverse-direction crossbar signals: per-output binding commands,
// per-input-VC payload in, routed payload/valid out, sticky error flag.
interface rev_xbar_vc_bind_if #(
  parameter int NUM_PORTS      = 5,
  parameter int NUM_VCS        = 2,
  parameter int CH_BITS        = 8,
  parameter int PORT_BANDWIDTH = CH_BITS
);
  localparam int PSEL_BITS = (NUM_PORTS > 2) ? $clog2(NUM_PORTS - 1) : 1;
  localparam int VCID_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

  // Handshake: bind_vld/unbind are single-cycle commands with no ready; every
  // command is consumed on the rising edge it is seen, out_vld qualifies outport.
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PORT_BANDWIDTH-1:0] inport;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                     bind_vld;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PSEL_BITS-1:0]      bind_psel;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][VCID_BITS-1:0]      bind_vcsel;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                     unbind;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PORT_BANDWIDTH-1:0] outport;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                     out_vld;
  logic                                                  bind_err;

  modport master (
    output inport, bind_vld, bind_psel, bind_vcsel, unbind,
    input  outport, out_vld, bind_err
  );

  modport slave (
    input  inport, bind_vld, bind_psel, bind_vcsel, unbind,
    output outport, out_vld, bind_err
  );
endinterface

// File: rtl/rev_xbar_vc_bind.sv
// Reverse crossbar: each output VC binds to one (port, VC) source of another port.
// Define REV_XBAR_OUTREG_EN to register outport/out_vld (one extra cycle of latency).
module rev_xbar_vc_bind #(
  parameter int NUM_PORTS      = 5,
  parameter int NUM_VCS        = 2,
  parameter int CH_BITS        = 8,
  parameter int PORT_BANDWIDTH = CH_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  rev_xbar_vc_bind_if.slave                 xbar,
  output logic [NUM_PORTS-1:0][NUM_VCS-1:0] dbg_state_o
);
  localparam int PSEL_BITS = (NUM_PORTS > 2) ? $clog2(NUM_PORTS - 1) : 1;
  localparam int VCID_BITS = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
  localparam int SRC_BITS  = $clog2(NUM_PORTS);
  localparam int PSEL_CODES = 1 << PSEL_BITS;
  localparam int VCID_CODES = 1 << VCID_BITS;

  // Bit i set when code i is a legal select; low NUM_PORTS-1 / NUM_VCS codes only.
  localparam logic [PSEL_CODES-1:0] PSEL_LEGAL =
    {PSEL_CODES{1'b1}} >> (PSEL_CODES - (NUM_PORTS - 1));
  localparam logic [VCID_CODES-1:0] VCID_LEGAL =
    {VCID_CODES{1'b1}} >> (VCID_CODES - NUM_VCS);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BOUND = 1'b1
  } state_e;

  state_e state_q [NUM_PORTS][NUM_VCS];
  state_e state_d [NUM_PORTS][NUM_VCS];

  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PSEL_BITS-1:0]      psel_q, psel_d;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][VCID_BITS-1:0]      vcsel_q, vcsel_d;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                     bind_ok, bind_bad;
  logic                                                  bind_err_q, bind_err_d;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PORT_BANDWIDTH-1:0] out_comb;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                     vld_comb;

  // The port's own index is skipped: codes at or above p map one port higher.
  function automatic logic [SRC_BITS-1:0] decode_src(
    input logic [PSEL_BITS-1:0] psel,
    input int                   port
  );
    logic [SRC_BITS-1:0] src;
    src = SRC_BITS'(psel);
    if (src >= SRC_BITS'(port)) begin
      src = src + SRC_BITS'(1);
    end
    return src;
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        bind_ok[p][v]  = xbar.bind_vld[p][v] &&
                         PSEL_LEGAL[xbar.bind_psel[p][v]] &&
                         VCID_LEGAL[xbar.bind_vcsel[p][v]];
        bind_bad[p][v] = xbar.bind_vld[p][v] && !bind_ok[p][v];
      end
    end
  end

  always_comb begin
    bind_err_d = bind_err_q | (|bind_bad);
    psel_d     = psel_q;
    vcsel_d    = vcsel_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        state_d[p][v] = state_q[p][v];
        case (state_q[p][v])
          ST_IDLE: begin
            if (bind_ok[p][v]) begin
              state_d[p][v] = ST_BOUND;
              psel_d[p][v]  = xbar.bind_psel[p][v];
              vcsel_d[p][v] = xbar.bind_vcsel[p][v];
            end
          end
          ST_BOUND: begin
            // Any bind_vld, even an illegal one, suppresses a same-cycle unbind.
            if (bind_ok[p][v]) begin
              psel_d[p][v]  = xbar.bind_psel[p][v];
              vcsel_d[p][v] = xbar.bind_vcsel[p][v];
            end else if (xbar.unbind[p][v] && !xbar.bind_vld[p][v]) begin
              state_d[p][v] = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bind_err_q <= 1'b0;
      psel_q     <= '0;
      vcsel_q    <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          state_q[p][v] <= ST_IDLE;
        end
      end
    end else begin
      bind_err_q <= bind_err_d;
      psel_q     <= psel_d;
      vcsel_q    <= vcsel_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        for (int v = 0; v < NUM_VCS; v++) begin
          state_q[p][v] <= state_d[p][v];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        dbg_state_o[p][v] = (state_q[p][v] == ST_BOUND);
        vld_comb[p][v]    = (state_q[p][v] == ST_BOUND);
        out_comb[p][v]    = '0;
        if (state_q[p][v] == ST_BOUND) begin
          out_comb[p][v] = xbar.inport[decode_src(psel_q[p][v], p)][vcsel_q[p][v]];
        end
      end
    end
  end

  assign xbar.bind_err = bind_err_q;

`ifdef REV_XBAR_OUTREG_EN
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PORT_BANDWIDTH-1:0] outport_q;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]                     out_vld_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outport_q <= '0;
      out_vld_q <= '0;
    end else begin
      outport_q <= out_comb;
      out_vld_q <= vld_comb;
    end
  end

  assign xbar.outport = outport_q;
  assign xbar.out_vld = out_vld_q;
`else
  assign xbar.outport = out_comb;
  assign xbar.out_vld = vld_comb;
`endif

endmodule

// File: tb/tb_rev_xbar_vc_bind.sv
// Scoreboard bench for rev_xbar_vc_bind: directed binding scenarios followed by
// random bind/unbind/reset traffic, checked against a table-based binding model.
`timescale 1ns/1ps
module tb_rev_xbar_vc_bind;
  localparam int NP     = 6;
  localparam int NV     = 3;
  localparam int W      = 8;
  localparam int PB     = (NP > 2) ? $clog2(NP - 1) : 1;
  localparam int VB     = (NV > 1) ? $clog2(NV) : 1;
  localparam int DW     = NP * NV * W;
  localparam int N_RAND = 600;

  typedef struct packed {
    logic [NP-1:0][NV-1:0][W-1:0] data;
    logic [NP-1:0][NV-1:0]        vld;
    logic [NP-1:0][NV-1:0]        st;
    logic                         err;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  logic [NP-1:0][NV-1:0] dbg_state;
  always #5 clk = ~clk;

  rev_xbar_vc_bind_if #(.NUM_PORTS(NP), .NUM_VCS(NV), .CH_BITS(W), .PORT_BANDWIDTH(W)) intf ();

  rev_xbar_vc_bind #(.NUM_PORTS(NP), .NUM_VCS(NV), .CH_BITS(W), .PORT_BANDWIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .xbar        (intf),
    .dbg_state_o (dbg_state)
  );

  // command staging
  logic [NP-1:0][NV-1:0][W-1:0]  cur_inport;
  logic [NP-1:0][NV-1:0]         cur_bind_vld;
  logic [NP-1:0][NV-1:0][PB-1:0] cur_psel;
  logic [NP-1:0][NV-1:0][VB-1:0] cur_vcsel;
  logic [NP-1:0][NV-1:0]         cur_unbind;
  logic                          cur_rst_n;

  // reference model: binding table indexed by output (p,v)
  bit m_bound [NP][NV];
  int m_src   [NP][NV];
  int m_vc    [NP][NV];
  bit m_err;
  logic [NP-1:0][NV-1:0][W-1:0] reg_data;
  logic [NP-1:0][NV-1:0]        reg_vld;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_en   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        m_bound[p][v] = 1'b0;
        m_src[p][v]   = 0;
        m_vc[p][v]    = 0;
      end
    end
    m_err = 1'b0;
  endtask

  task automatic clear_cmds();
    cur_bind_vld = '0;
    cur_unbind   = '0;
    cur_psel     = '0;
    cur_vcsel    = '0;
    cur_rst_n    = 1'b1;
  endtask

  task automatic rand_inport();
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        cur_inport[p][v] = W'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic bind_cmd(input int p, input int v, input int ps, input int vc);
    cur_bind_vld[p][v] = 1'b1;
    cur_psel[p][v]     = PB'(ps);
    cur_vcsel[p][v]    = VB'(vc);
  endtask

  // driver: present staged commands, queue the response due before the next edge
  task automatic drive_step();
    exp_t e;
    logic [NP-1:0][NV-1:0][W-1:0] comb_data;
    logic [NP-1:0][NV-1:0]        comb_vld;
    @(posedge clk);
    #1;
    intf.inport     = cur_inport;
    intf.bind_vld   = cur_bind_vld;
    intf.bind_psel  = cur_psel;
    intf.bind_vcsel = cur_vcsel;
    intf.unbind     = cur_unbind;
    rst_n           = cur_rst_n;
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        comb_vld[p][v]  = m_bound[p][v];
        comb_data[p][v] = m_bound[p][v] ? cur_inport[m_src[p][v]][m_vc[p][v]] : '0;
        e.st[p][v]      = m_bound[p][v];
      end
    end
    e.err = m_err;
`ifdef REV_XBAR_OUTREG_EN
    e.data   = reg_data;
    e.vld    = reg_vld;
    reg_data = cur_rst_n ? comb_data : '0;
    reg_vld  = cur_rst_n ? comb_vld : '0;
`else
    e.data = comb_data;
    e.vld  = comb_vld;
`endif
    exp_q.push_back(e);
    mon_en = 1'b1;
    if (!cur_rst_n) begin
      model_reset();
    end else begin
      for (int p = 0; p < NP; p++) begin
        for (int v = 0; v < NV; v++) begin
          if (cur_bind_vld[p][v]) begin
            if (int'(cur_psel[p][v]) <= NP - 2 && int'(cur_vcsel[p][v]) <= NV - 1) begin
              m_bound[p][v] = 1'b1;
              m_src[p][v]   = (int'(cur_psel[p][v]) < p) ? int'(cur_psel[p][v])
                                                         : int'(cur_psel[p][v]) + 1;
              m_vc[p][v]    = int'(cur_vcsel[p][v]);
            end else begin
              m_err = 1'b1;
            end
          end else if (cur_unbind[p][v]) begin
            m_bound[p][v] = 1'b0;
          end
        end
      end
    end
  endtask

  // monitor: one expected response per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow at %0t: got empty queue expected an entry", $time);
        end else begin
          e = exp_q.pop_front();
          check("outport",   DW'(intf.outport),  DW'(e.data));
          check("out_vld",   DW'(intf.out_vld),  DW'(e.vld));
          check("fsm_state", DW'(dbg_state),     DW'(e.st));
          check("bind_err",  DW'(intf.bind_err), DW'(e.err));
        end
      end
    end
  end

  initial begin
    clear_cmds();
    rand_inport();
    cur_rst_n       = 1'b0;
    rst_n           = 1'b0;
    intf.inport     = cur_inport;
    intf.bind_vld   = '0;
    intf.bind_psel  = '0;
    intf.bind_vcsel = '0;
    intf.unbind     = '0;
    model_reset();
    reg_data = '0;
    reg_vld  = '0;
    repeat (3) @(posedge clk);

    // reset state, then bind (2,1) to port 3 vc 0
    clear_cmds(); rand_inport(); drive_step();
    clear_cmds(); rand_inport(); bind_cmd(2, 1, 2, 0); cur_inport[3][0] = 8'hA5; drive_step();
    clear_cmds(); rand_inport(); cur_inport[3][0] = 8'hA5; drive_step();
    clear_cmds(); rand_inport(); cur_inport[3][0] = 8'hA5; drive_step();

    // rebind (2,1) below own port: port 1 vc 1
    clear_cmds(); rand_inport(); bind_cmd(2, 1, 1, 1); cur_inport[1][1] = 8'h3C; drive_step();
    clear_cmds(); rand_inport(); cur_inport[1][1] = 8'h3C; drive_step();
    clear_cmds(); rand_inport(); cur_inport[1][1] = 8'h3C; drive_step();

    // bind and unbind together: bind wins
    clear_cmds(); rand_inport(); bind_cmd(0, 0, 0, 0); drive_step();
    clear_cmds(); rand_inport(); bind_cmd(0, 0, 3, 1); cur_unbind[0][0] = 1'b1; drive_step();
    clear_cmds(); rand_inport(); drive_step();
    clear_cmds(); rand_inport(); drive_step();

    // unbind in idle, then a real unbind
    clear_cmds(); rand_inport(); cur_unbind[4][2] = 1'b1; drive_step();
    clear_cmds(); rand_inport(); cur_unbind[2][1] = 1'b1; drive_step();
    clear_cmds(); rand_inport(); drive_step();

    // illegal selects are ignored and make bind_err sticky
    clear_cmds(); rand_inport(); bind_cmd(1, 0, 5, 0); drive_step();
    clear_cmds(); rand_inport(); drive_step();
    clear_cmds(); rand_inport(); bind_cmd(1, 0, 0, 3); drive_step();
    clear_cmds(); rand_inport(); bind_cmd(3, 2, 7, 1); cur_unbind[0][0] = 1'b1; drive_step();
    clear_cmds(); rand_inport(); bind_cmd(0, 0, 6, 0); cur_unbind[0][0] = 1'b1; drive_step();
    repeat (3) begin clear_cmds(); rand_inport(); drive_step(); end

    // bind four outputs, then reset while binding
    clear_cmds(); rand_inport();
    bind_cmd(0, 1, 0, 0); bind_cmd(1, 1, 1, 1); bind_cmd(4, 0, 4, 2); bind_cmd(5, 2, 2, 0);
    drive_step();
    clear_cmds(); rand_inport(); drive_step();
    clear_cmds(); rand_inport(); bind_cmd(2, 2, 1, 1); cur_rst_n = 1'b0; drive_step();
    repeat (2) begin clear_cmds(); rand_inport(); drive_step(); end

    // random traffic
    for (int i = 0; i < N_RAND; i++) begin
      clear_cmds();
      rand_inport();
      for (int p = 0; p < NP; p++) begin
        for (int v = 0; v < NV; v++) begin
          if ($urandom_range(0, 5) == 0) bind_cmd(p, v, $urandom_range(0, (1 << PB) - 1),
                                                  $urandom_range(0, (1 << VB) - 1));
          if ($urandom_range(0, 5) == 0) cur_unbind[p][v] = 1'b1;
        end
      end
      if ($urandom_range(0, 59) == 0) cur_rst_n = 1'b0;
      drive_step();
    end

    clear_cmds(); rand_inport(); drive_step();
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d entries left expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
